// File: rtl/booth_multiplier.sv
// Signed 32x32 multiplier using radix-2 Booth recoding, one step per clock.
// The result is the low 32 bits of the product, plus a flag for signed overflow.
module booth_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d, m_q, m_d, sum;
  logic [31:0] q_q, q_d, res_q, res_d;
  logic        qm1_q, qm1_d, exc_q, exc_d;
  logic [5:0]  cnt_q, cnt_d;

  // The adder is 33 bits wide so that M = -2^31 can be negated exactly.
  always_comb begin
    sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (ctrl_MULT) begin
      // A start strobe restarts the operation from any state, including mid-run.
      state_d = RUN;
      acc_d   = '0;
      q_d     = data_operandB;
      qm1_d   = 1'b0;
      m_d     = {data_operandA[31], data_operandA};
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          acc_d = {sum[32], sum[32:1]};
          q_d   = {sum[0], q_q[31:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = DONE;
            res_d   = q_d;
            exc_d   = (acc_d[31:0] != {32{q_d[31]}});
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no parameters.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 ctrl_MULT  input  1  start strobe, sampled on the rising clock edge.
REQ-005 data_operandA  input  32  signed two's-complement multiplicand, captured when ctrl_MULT is sampled high.
REQ-006 data_operandB  input  32  signed two's-complement multiplier, captured when ctrl_MULT is sampled high.
REQ-007 data_result  output  32  low 32 bits of the signed 64-bit product.
REQ-008 data_exception  output  1  signed overflow of the 32-bit result.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception valid.
REQ-010 busy  output  1  high while a multiply is in progress.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, RUN and DONE.
REQ-012 IDLE SHALL go to RUN on any edge where ctrl_MULT=1, capturing the operands and clearing the step counter.
REQ-013 Captured state SHALL be:
- a 33-bit accumulator ACC cleared to 0;
- Q = operandB;
- q_m1 = 0;
- a 33-bit multiplicand M = sign-extended operandA.
REQ-014 RUN SHALL perform one radix-2 Booth step per cycle, using {Q[0], q_m1}:
- 01: ACC += M;
- 10: ACC -= M;
- 00 or 11: ACC unchanged;
- then arithmetic right shift of {ACC, Q, q_m1} by one bit.
REQ-015 ACC add/subtract SHALL be 33-bit two's complement so that operandA = 0x80000000 is exact.
REQ-016 A 6-bit step counter SHALL increment each RUN cycle; the block SHALL go RUN->DONE on the edge completing step 32.
REQ-017 Latency: the start edge is E0; step k completes on edge Ek; data_resultRDY SHALL be 1 for exactly the cycle after E32.
REQ-018 DONE SHALL go to IDLE on the next edge unless ctrl_MULT=1 on that edge, in which case it SHALL go to RUN with a new capture as in REQ-012.
REQ-019 data_result SHALL be product[31:0], where product = {ACC[31:0], Q} after step 32.
REQ-020 data_exception SHALL be 1 iff product[63:32] differs from 32 copies of product[31].
REQ-021 data_result and data_exception SHALL be registered, updated only on the edge entering DONE, and held through IDLE until the next completion.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-023 ctrl_MULT=1 during RUN SHALL abort the current operation and restart it per REQ-012:
- no data_resultRDY for the aborted operation;
- latency restarts from that edge.
REQ-024 Operand inputs SHALL be ignored except on capture edges.
REQ-025 data_resultRDY SHALL never be high for two consecutive cycles unless a restart occurs from DONE and a further 32 steps complete.

Reset
REQ-026 reset=0 SHALL, asynchronously and regardless of state:
- force state to IDLE;
- set data_result=0, data_exception=0, data_resultRDY=0, busy=0;
- clear ACC, Q, q_m1, M and the counter.
REQ-027 Reset asserted mid-RUN SHALL discard the operation, with no data_resultRDY pulse after release.
REQ-028 After reset release, the first edge with ctrl_MULT=1 SHALL start a multiply normally.

Verification
REQ-029 The bench SHALL cover at least the following directed scenarios:
- A=3, B=5, one-cycle ctrl_MULT -> 32 cycles later data_resultRDY=1 for one cycle, data_result=15, data_exception=0, busy high for the 32 intervening cycles.
- A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), data_exception=0; then A=-1, B=-1 -> data_result=1, data_exception=0.
- A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1; A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- Start A=2, B=3, then at step 10 reassert ctrl_MULT with A=4, B=5 -> exactly one data_resultRDY, 32 cycles after the second start, data_result=20.
- Start A=9, B=9, drive reset=0 at step 20 asynchronously between edges -> outputs zero immediately, no data_resultRDY after release; a new A=9, B=9 start yields 81.
- Back-to-back: ctrl_MULT=1 in the DONE cycle with A=0x7FFFFFFF, B=2 -> first result valid, second result 0xFFFFFFFE with data_exception=1, 32 cycles later.
